reg_access_arbiter: RTL
=======================

Name: reg_access_arbiter

Overview:
- Shares the single-port configuration register file between two requesters: the SPI slave path (decoded write/addr/wdata transactions, already synchronised into `clk`) and on-chip core logic (trigger/readout sequencers).
- Grants one access at a time, drives the register-file port and returns read data with a one-cycle response pulse.
- Uses fixed SPI priority, with an anti-starvation override for the core requester.

Parameters:
- ADDR_W, 7, register address width (matches the 7-bit SPI address field)
- DATA_W, 8, register data width
- NUM_REGS, 64, number of implemented registers; addresses >= NUM_REGS are out of range
- RD_LAT, 1, register-file read latency in cycles (1..4)
- STARVE_MAX, 4, consecutive lost arbitrations after which the core requester gets priority
- PROT_REGS, 8, addresses 0..PROT_REGS-1 are write-protectable (optional feature)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- spi_req_valid  in  1  SPI access request
- spi_req_ready  out  1  SPI request accepted this cycle
- spi_req_write  in  1  1 = write, 0 = read
- spi_req_addr  in  ADDR_W  SPI target address
- spi_req_wdata  in  DATA_W  SPI write data
- spi_rsp_valid  out  1  one-cycle SPI completion pulse
- spi_rsp_rdata  out  DATA_W  SPI read data, valid with spi_rsp_valid
- core_req_valid  in  1  core access request
- core_req_ready  out  1  core request accepted this cycle
- core_req_write  in  1  1 = write, 0 = read
- core_req_addr  in  ADDR_W  core target address
- core_req_wdata  in  DATA_W  core write data
- core_rsp_valid  out  1  one-cycle core completion pulse
- core_rsp_rdata  out  DATA_W  core read data
- rf_en  out  1  register-file access strobe
- rf_we  out  1  register-file write enable (only with rf_en)
- rf_addr  out  ADDR_W  register-file address
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read data, RD_LAT cycles after rf_en
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0; starvation counter 0; owner register 0.
  - Reset mid-access abandons the access; no response pulse is issued.
- Handshake:
  - A request transfers when valid && ready.
  - ready is combinational and is asserted only in IDLE, only for the granted requester.
  - The requester holds valid and payload stable until ready is seen.
  - Only one access is outstanding at a time.
- Arbitration (in IDLE):
  - Only one requester valid: that requester is granted.
  - Both valid: SPI is granted unless starve_cnt == STARVE_MAX, in which case core is granted.
  - starve_cnt:
    - +1 each cycle core_req_valid is high and core is not granted.
    - Saturates at STARVE_MAX.
    - Cleared on a core grant.
- FSM states IDLE -> ACCESS -> WAIT -> RESP -> IDLE:
  - IDLE: on grant, latch write, addr, wdata and owner, then go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - In range: rf_en=1, rf_we=write, rf_addr and rf_wdata driven from the latched values.
    - Out of range: rf_en=0 and rf_we=0.
    - Next state: writes go to RESP; reads go to WAIT.
  - WAIT: counts RD_LAT cycles after ACCESS, then captures rf_rdata (0xFF..F if the address was out of range) and goes to RESP.
  - RESP (1 cycle):
    - owner's rsp_valid=1; rsp_rdata = captured data for reads, 0 for writes.
    - The other requester's rsp_valid stays 0. Next state: IDLE.
- Timing:
  - Write: ACCESS in the cycle after handshake; rsp_valid 2 cycles after handshake.
  - Read: rsp_valid 2+RD_LAT cycles after handshake.
  - Back-to-back grants: the next handshake can occur in the cycle after RESP.
- rsp_rdata holds its value until the next response to the same requester.
- rf_addr, rf_wdata and rf_we are 0 whenever rf_en = 0.
- Out-of-range write: dropped silently, response still issued.

Optional Feature:
- Macro REG_WRITE_LOCK_EN adds input `wr_lock` (1 bit).
- Defined:
  - While wr_lock=1 (sampled in ACCESS), any write to an address < PROT_REGS is suppressed (rf_en=0).
  - Response timing is unchanged.
  - A sticky output `lock_viol` (1 bit) sets on a suppressed write and clears only on rst.
  - Reads are unaffected.
- Undefined: port `wr_lock` and output `lock_viol` are absent; all in-range writes proceed.

Test Plan:
- SPI write addr 0x05 data 0xA5 -> next cycle rf_en=1, rf_we=1, rf_addr=0x05, rf_wdata=0xA5; spi_rsp_valid 2 cycles after handshake, rdata 0x00; core_rsp_valid stays 0.
- Core read addr 0x10, rf_rdata=0x3C, RD_LAT=1 -> core_rsp_valid 3 cycles after handshake, core_rsp_rdata=0x3C.
- Both requesters valid continuously for 20 cycles -> SPI granted 4 times, then core granted once; pattern repeats; starve_cnt resets after the core grant.
- Read addr 0x50 (>= NUM_REGS) -> rf_en never asserts; rsp_rdata=0xFF at the normal read latency. Write to addr 0x7F -> rf_en never asserts; response still issued.
- rst asserted in WAIT of a read -> next cycle busy=0, all outputs 0, no rsp_valid; a new request is accepted the following cycle.
- REG_WRITE_LOCK_EN: wr_lock=1, write addr 0x03 -> rf_en=0, lock_viol=1, response issued. Write addr 0x08 -> rf_en=1, rf_we=1. lock_viol stays 1 until rst.

Source files
------------

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_arbiter
// Purpose  : Shares the single-port configuration register file between the
//            SPI slave path and the on-chip core sequencers. One access is in
//            flight at a time. SPI has fixed priority, except that the core
//            requester wins once it has lost STARVE_MAX arbitrations in a row.
//            Each access ends with a one-cycle response pulse to its owner.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            spi_req_* / spi_rsp_*     - SPI request/response channel
//            core_req_* / core_rsp_*   - core request/response channel
//            rf_en/we/addr/wdata/rdata - register-file port
//            busy                      - high whenever the FSM is not idle
//            wr_lock, lock_viol        - only with REG_WRITE_LOCK_EN defined
// Options  : REG_WRITE_LOCK_EN - adds wr_lock, which suppresses writes to
//            addresses below PROT_REGS, and the sticky lock_viol flag.
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_REGS   = 64,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned PROT_REGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_req_valid,
  output logic              spi_req_ready,
  input  logic              spi_req_write,
  input  logic [ADDR_W-1:0] spi_req_addr,
  input  logic [DATA_W-1:0] spi_req_wdata,
  output logic              spi_rsp_valid,
  output logic [DATA_W-1:0] spi_rsp_rdata,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_write,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
`ifdef REG_WRITE_LOCK_EN
  input  logic              wr_lock,
  output logic              lock_viol,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int unsigned          c_STV_W      = $clog2(STARVE_MAX + 1);
  localparam logic [c_STV_W-1:0]   c_STARVE_MAX = c_STV_W'(STARVE_MAX);
  localparam logic [2:0]           c_RD_LAT     = 3'(RD_LAT);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;      // 0 = SPI, 1 = core
  logic [2:0]          lat_q, lat_d;
  logic [c_STV_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0]   spi_rdata_q, spi_rdata_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;

  logic                w_grant_spi;
  logic                w_grant_core;
  logic                w_in_range;
  logic                w_lock_req;
  logic                w_lock_block;
  logic [DATA_W-1:0]   w_rd_capture;

  // Core wins if it is alone, or if it has been starved long enough.
  assign w_grant_core = core_req_valid && (!spi_req_valid || (starve_q == c_STARVE_MAX));
  assign w_grant_spi  = spi_req_valid && !w_grant_core;

  assign w_in_range   = (32'(addr_q) < NUM_REGS);
  // Out-of-range reads never touch the register file and return all ones.
  assign w_rd_capture = w_in_range ? rf_rdata : {DATA_W{1'b1}};

`ifdef REG_WRITE_LOCK_EN
  assign w_lock_req = wr_lock;
`else
  assign w_lock_req = 1'b0;
`endif
  assign w_lock_block = w_lock_req && write_q && (32'(addr_q) < PROT_REGS);

  assign busy           = (state_q != S_IDLE);
  assign spi_rsp_rdata  = spi_rdata_q;
  assign core_rsp_rdata = core_rdata_q;

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    owner_d        = owner_q;
    lat_d          = lat_q;
    starve_d       = starve_q;
    spi_rdata_d    = spi_rdata_q;
    core_rdata_d   = core_rdata_q;
    spi_req_ready  = 1'b0;
    core_req_ready = 1'b0;
    spi_rsp_valid  = 1'b0;
    core_rsp_valid = 1'b0;
    rf_en          = 1'b0;
    rf_we          = 1'b0;
    rf_addr        = '0;
    rf_wdata       = '0;

    case (state_q)
      S_IDLE: begin
        spi_req_ready  = w_grant_spi;
        core_req_ready = w_grant_core;
        // Only lost arbitrations in IDLE count towards starvation.
        if (w_grant_core) begin
          starve_d = '0;
        end else if (core_req_valid && (starve_q != c_STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
        if (w_grant_spi || w_grant_core) begin
          write_d = w_grant_core ? core_req_write : spi_req_write;
          addr_d  = w_grant_core ? core_req_addr  : spi_req_addr;
          wdata_d = w_grant_core ? core_req_wdata : spi_req_wdata;
          owner_d = w_grant_core;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (w_in_range && !w_lock_block) begin
          rf_en    = 1'b1;
          rf_we    = write_q;
          rf_addr  = addr_q;
          rf_wdata = wdata_q;
        end
        lat_d = 3'd1;
        if (write_q) begin
          // Writes return zero data; load it now so it is stable in RESP.
          if (owner_q) core_rdata_d = '0;
          else         spi_rdata_d  = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (lat_q == c_RD_LAT) begin
          if (owner_q) core_rdata_d = w_rd_capture;
          else         spi_rdata_d  = w_rd_capture;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      S_RESP: begin
        spi_rsp_valid  = !owner_q;
        core_rsp_valid = owner_q;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      lat_q        <= '0;
      starve_q     <= '0;
      spi_rdata_q  <= '0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      spi_rdata_q  <= spi_rdata_d;
      core_rdata_q <= core_rdata_d;
    end
  end

`ifdef REG_WRITE_LOCK_EN
  logic lock_viol_q, lock_viol_d;

  // Sticky: once a protected write has been dropped it stays flagged.
  assign lock_viol_d = lock_viol_q || ((state_q == S_ACCESS) && w_lock_block);
  assign lock_viol   = lock_viol_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_viol_q <= 1'b0;
    end else begin
      lock_viol_q <= lock_viol_d;
    end
  end
`endif

endmodule
`default_nettype wire
